// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the fetch FSM state enum, the MIPS break encoding and the instruction size.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] HALT_WORD   = 32'h0000_000D;
    localparam int          INSTR_BYTES = 4;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/imem_fetch_perf.sv
// Fetch performance counters: instructions fetched and stalled FETCH cycles.
// Only instantiated when IMEM_FETCH_PERF_EN is defined.
module imem_fetch_perf
    import imem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_fetch_inc,
    input  logic        i_stall_inc,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_stall_count
);

    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    // Both counters wrap naturally at 2^32; clear takes priority over counting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else if (i_clear) begin
            r_fetch_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (i_fetch_inc) r_fetch_count <= r_fetch_count + 32'd1;
            if (i_stall_inc) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_fetch_count = r_fetch_count;
    assign o_stall_count = r_stall_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction memory address and registers
// the returned word. Optional performance counters are enabled by IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    output logic        o_busy,
    output logic        o_halted,
    output logic        o_fault,
    output logic [31:0] o_fault_pc,
    output logic [31:0] o_fetch_count,
    output logic [31:0] o_stall_count
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * INSTR_BYTES);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic [31:0] r_fault_pc;

    logic w_in_fetch;
    logic w_pc_bad;
    logic w_start_accept;
    logic w_fetch_fire;

    assign w_in_fetch     = (r_state == ST_FETCH);
    assign w_pc_bad       = pc_misaligned(r_pc) || (r_pc >= IMEM_BYTES);
    assign w_start_accept = i_start && !w_in_fetch;
    assign w_fetch_fire   = w_in_fetch && !i_redirect_valid && !w_pc_bad && !i_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Priority inside FETCH: redirect, then fault check, then stall, then fetch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH: begin
                if (i_redirect_valid)               w_state_next = ST_FETCH;
                else if (w_pc_bad)                  w_state_next = ST_FAULT;
                else if (i_stall)                   w_state_next = ST_FETCH;
                else if (i_imem_rdata == HALT_WORD) w_state_next = ST_HALT;
                else                                w_state_next = ST_FETCH;
            end
            default: begin
                if (i_start) w_state_next = ST_FETCH;
            end
        endcase
    end

    always_comb begin
        o_busy   = (r_state == ST_FETCH);
        o_halted = (r_state == ST_HALT);
        o_fault  = (r_state == ST_FAULT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_fault_pc    <= '0;
        end else if (w_in_fetch) begin
            if (i_redirect_valid) begin
                r_pc          <= i_redirect_pc;
                r_instr_valid <= 1'b0;
            end else if (w_pc_bad) begin
                r_fault_pc    <= r_pc;
                r_instr_valid <= 1'b0;
            end else if (!i_stall) begin
                r_instr       <= i_imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + 32'(INSTR_BYTES);
            end
        end else begin
            // Outside FETCH the last word (e.g. the break) is retired after one cycle.
            r_instr_valid <= 1'b0;
            if (w_start_accept) r_pc <= RESET_PC;
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_fault_pc    = r_fault_pc;

`ifdef IMEM_FETCH_PERF_EN
    logic w_stall_fire;
    assign w_stall_fire = w_in_fetch && i_stall && !i_redirect_valid;

    imem_fetch_perf u_perf (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clear       (w_start_accept),
        .i_fetch_inc   (w_fetch_fire),
        .i_stall_inc   (w_stall_fire),
        .o_fetch_count (o_fetch_count),
        .o_stall_count (o_stall_count)
    );
`else
    logic w_perf_unused;
    assign w_perf_unused = w_fetch_fire;
    assign o_fetch_count = 32'd0;
    assign o_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed testbench for imem_fetch_ctrl with a small behavioural instruction memory.
// Counter expectations follow IMEM_FETCH_PERF_EN.
module tb_imem_fetch_ctrl;
    import imem_pkg::*;

`ifdef IMEM_FETCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    logic [31:0] mem [0:255];
    logic [31:0] rom [0:4];

    int nChecks = 0;
    int nFails  = 0;

    imem_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_imem_addr      (imem_addr),
        .i_imem_rdata     (imem_rdata),
        .o_instr          (instr),
        .o_instr_pc       (instr_pc),
        .o_instr_valid    (instr_valid),
        .o_busy           (busy),
        .o_halted         (halted),
        .o_fault          (fault),
        .o_fault_pc       (fault_pc),
        .o_fetch_count    (fetch_count),
        .o_stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        imem_rdata = 32'd0;
        if (imem_addr < 32'd1024) imem_rdata = mem[imem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rom[0] = 32'h2008_0001;
        rom[1] = 32'h2009_0002;
        rom[2] = 32'h0109_5020;
        rom[3] = 32'hAC0A_0000;
        rom[4] = HALT_WORD;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 5; i++) mem[i] = rom[i];

        #2 rst_n = 1'b0;
        tick();
        check("rst_addr", imem_addr, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Straight-line fetch ending on break
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_addr0", imem_addr, 32'd0);
        check("t1_valid0", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_instr", instr, rom[i]);
            check("t1_ipc", instr_pc, 32'(4 * i));
            check("t1_valid", {31'd0, instr_valid}, 32'd1);
            check("t1_addr", imem_addr, 32'(4 * i + 4));
        end
        check("t1_halted_entry", {31'd0, halted}, 32'd1);
        tick();
        check("t1_halted", {31'd0, halted}, 32'd1);
        check("t1_valid_drop", {31'd0, instr_valid}, 32'd0);
        check("t1_busy_off", {31'd0, busy}, 32'd0);
        check("t1_fetch_count", fetch_count, PERF ? 32'd5 : 32'd0);

        // Stall at pc=8 for three cycles
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_addr0", imem_addr, 32'd0);
        tick();
        tick();
        check("t2_addr8", imem_addr, 32'd8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_ipc", instr_pc, 32'd4);
            check("t2_hold_instr", instr, rom[1]);
            check("t2_hold_addr", imem_addr, 32'd8);
            check("t2_hold_valid", {31'd0, instr_valid}, 32'd1);
        end
        check("t2_stall_count", stall_count, PERF ? 32'd3 : 32'd0);

        // Redirect wins over stall at pc=12
        stall = 1'b0;
        tick();
        check("t3_addr12", imem_addr, 32'd12);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("t3_addr_redir", imem_addr, 32'd0);
        check("t3_flush", {31'd0, instr_valid}, 32'd0);
        check("t3_stall_count", stall_count, PERF ? 32'd3 : 32'd0);
        tick();
        check("t3_ipc", instr_pc, 32'd0);
        check("t3_instr", instr, rom[0]);
        check("t3_valid", {31'd0, instr_valid}, 32'd1);
        check("t3_fetch_count", fetch_count, PERF ? 32'd4 : 32'd0);

        // Misaligned redirect faults on the following cycle
        redirect_valid = 1'b1;
        redirect_pc = 32'd6;
        tick();
        redirect_valid = 1'b0;
        check("t4_addr6", imem_addr, 32'd6);
        check("t4_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t4_fault", {31'd0, fault}, 32'd1);
        check("t4_fault_pc", fault_pc, 32'd6);
        check("t4_valid", {31'd0, instr_valid}, 32'd0);
        check("t4_addr_hold", imem_addr, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        check("t4_ignore_redir", imem_addr, 32'd6);
        check("t4_still_fault", {31'd0, fault}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_fault_clr", {31'd0, fault}, 32'd0);
        check("t4_resume_addr", imem_addr, 32'd0);
        tick();
        check("t4_resume_ipc", instr_pc, 32'd0);
        check("t4_resume_valid", {31'd0, instr_valid}, 32'd1);

        // Out-of-range redirect at exactly the memory size
        redirect_valid = 1'b1;
        redirect_pc = 32'd1024;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t5_fault", {31'd0, fault}, 32'd1);
        check("t5_fault_pc", fault_pc, 32'd1024);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_start_ignored", imem_addr, 32'd8);
        check("t5_busy", {31'd0, busy}, 32'd1);
        check("t5_fetch_count", fetch_count, PERF ? 32'd2 : 32'd0);

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("t6_addr", imem_addr, 32'd0);
        check("t6_instr", instr, 32'd0);
        check("t6_ipc", instr_pc, 32'd0);
        check("t6_valid", {31'd0, instr_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_fault_pc", fault_pc, 32'd0);
        check("t6_fetch_count", fetch_count, 32'd0);
        check("t6_stall_count", stall_count, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_idle_busy", {31'd0, busy}, 32'd0);
        check("t6_idle_addr", imem_addr, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_restart_busy", {31'd0, busy}, 32'd1);
        tick();
        check("t6_restart_ipc", instr_pc, 32'd0);
        check("t6_restart_instr", instr, rom[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the single-cycle MIPS core. It owns the program counter and drives the word address into the combinational `InstructionMemory`. It registers the returned word into an instruction register for decode. It also handles start, stall, branch/jump redirect, halt on `break`, and address faults.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset and on every `start`
- `IMEM_WORDS`, 256, instruction memory depth in 32-bit words; byte addresses at or above `IMEM_WORDS*4` fault
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins fetching at `RESET_PC` from IDLE, HALT or FAULT
- `stall`  in  1  hold PC and instruction register
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_pc`  in  32  new PC when `redirect_valid`
- `imem_addr`  out  32  byte address to `InstructionMemory.address` (equals PC register)
- `imem_rdata`  in  32  word from `InstructionMemory.instruction`
- `instr`  out  32  registered instruction
- `instr_pc`  out  32  PC of `instr`
- `instr_valid`  out  1  `instr` is a live instruction
- `busy`  out  1  state is FETCH
- `halted`  out  1  state is HALT
- `fault`  out  1  state is FAULT
- `fault_pc`  out  32  offending PC, captured on fault entry
- `fetch_count`  out  32  instructions fetched (see Configuration)
- `stall_count`  out  32  FETCH cycles with `stall` high (see Configuration)

## Operation
- States: IDLE, FETCH, HALT, FAULT. Reset enters IDLE.
- IDLE/HALT/FAULT:
  - `start` moves to FETCH with pc=`RESET_PC`, `instr_valid`=0, `fault`=0.
  - `stall` and `redirect_valid` are ignored.
- FETCH, priority per cycle: redirect > fault check > stall > normal fetch.
  - **Redirect:** pc<=`redirect_pc`, `instr_valid`<=0 (flush). No fault check this cycle; the new PC is checked next cycle.
  - **Fault:** if pc[1:0]!=0 or pc>=`IMEM_WORDS*4`:
    - go to FAULT
    - `fault_pc`<=pc, `instr_valid`<=0
    - pc holds
  - **Stall:** pc, `instr`, `instr_pc` and `instr_valid` all hold.
  - **Normal fetch:**
    - `instr`<=`imem_rdata`, `instr_pc`<=pc, `instr_valid`<=1
    - pc<=pc+4, 32-bit wrapping add
    - if `imem_rdata`==`HALT_WORD` (MIPS `break`, 32'h0000_000D), state<=HALT; the `break` word is still presented valid for one cycle.
- HALT and FAULT entry: `instr_valid` drops on the cycle after the transition edge.
- `start` while in FETCH is ignored.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), with no partial update.

## Timing
- Reset values:
  - pc=`imem_addr`=`RESET_PC`
  - `instr`=0, `instr_pc`=0, `instr_valid`=0
  - `busy`=0, `halted`=0, `fault`=0, `fault_pc`=0
  - `fetch_count`=0, `stall_count`=0
- `imem_addr` is driven directly from the pc register; there is no combinational path from any input to `imem_addr`.
- Fetch latency: PC presented in cycle N; `instr` is valid from the edge ending cycle N.
- Throughput: one instruction per unstalled cycle.
- Redirect penalty: one bubble. `redirect_valid` at edge N sets `imem_addr`=`redirect_pc` in cycle N+1; that instruction is valid after edge N+1.
- `start` to first valid instruction: 2 edges (edge 1 enters FETCH, edge 2 latches the word at `RESET_PC`).
- Status outputs `busy`, `halted` and `fault` are decoded from the state register.

## Configuration
- `IMEM_FETCH_PERF_EN` defined:
  - `fetch_count` increments on every normal-fetch cycle.
  - `stall_count` increments on every FETCH cycle with `stall`=1 and `redirect_valid`=0.
  - Both counters wrap at 2^32 and clear on reset and on `start`.
- `IMEM_FETCH_PERF_EN` undefined: both outputs are constant 0 and no counter flops are instantiated. The ports remain present.

## Structure
- Shared package `imem_pkg` contains:
  - the state enum (IDLE, FETCH, HALT, FAULT)
  - `HALT_WORD`=32'h0000_000D
  - `INSTR_BYTES`=4
- Sub-module `imem_fetch_perf` holds the two counters. It is instantiated only under `IMEM_FETCH_PERF_EN`.
- Everything else (FSM, PC, instruction register) lives in `imem_fetch_ctrl`.

## Test plan
- Memory preloaded with 5 words at 0,4,8,12,16; word at 16 is 32'h0000_000D. Pulse `start` ->
  - `imem_addr` steps 0,4,8,12,16 on consecutive cycles
  - the 5 words appear with `instr_pc` 0..16
  - then `halted`=1, `instr_valid`=0
  - `fetch_count`=5 (macro on) or 0 (macro off)
- `stall`=1 for 3 cycles at pc=8 -> `instr`/`instr_pc`=4 held, `imem_addr`=8 held; `stall_count`=3 with macro on.
- `redirect_valid`=1 with `redirect_pc`=32'h0000_0000 while `stall`=1 at pc=12 -> next cycle `imem_addr`=0, `instr_valid`=0; one cycle later `instr_pc`=0 is valid.
- `redirect_pc`=32'h0000_0006 -> next cycle state FAULT, `fault`=1, `fault_pc`=6; `start` then clears `fault` and resumes at 0.
- `redirect_pc`=`IMEM_WORDS*4` (1024) -> FAULT with `fault_pc`=1024.
- Deassert `rst_n` mid-FETCH between clock edges -> all outputs return to reset values immediately; `start` is required to resume.
